// File: rtl/i2c_pkg.sv
// Shared definitions for the byte-level I2C master: command codes, FSM states
// and the quarter-phase bookkeeping used by every bit on the bus.
package i2c_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_READ  = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_STOP   = 3'd2,
        ST_DATA   = 3'd3,
        ST_ACKBIT = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam int unsigned NUM_QUARTERS = 4;

    typedef logic [1:0] quarter_t;

    function automatic logic quarter_is_last(input quarter_t q);
        return q == quarter_t'(NUM_QUARTERS - 1);
    endfunction

endpackage

// File: rtl/i2c_phase_timer.sv
// Quarter-phase tick generator: one tick every CLK_DIV clocks while enabled.
// The hold input freezes the count so a slave can stretch a quarter.
module i2c_phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic hold,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = en && !hold && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master executing START/STOP/WRITE/READ commands with
// quarter-bit SCL/SDA timing. Define I2C_CLOCK_STRETCH_EN to honour slave clock stretching.
module i2c_byte_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] wr_data,
    input  logic       rd_ack,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       ack_error,
    output logic       scl,
    input  logic       scl_in,
    output logic       sda_oe,
    input  logic       sda_in
);

    state_e     state_q, state_d;
    quarter_t   quarter_q, quarter_d;
    logic [2:0] bit_q, bit_d;
    cmd_e       cmd_q, cmd_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       ack_error_q, ack_error_d;
    logic       park_scl_q, park_scl_d;
    logic       park_sda_q, park_sda_d;

    logic [7:0] wdata_q, wdata_d;
    logic       rd_ack_q, rd_ack_d;
    logic [7:0] shift_q, shift_d;
    logic       ack_samp_q, ack_samp_d;

    logic       tick;
    logic       hold;
    logic       timer_en;

    assign timer_en = (state_q == ST_START) || (state_q == ST_STOP) ||
                      (state_q == ST_DATA)  || (state_q == ST_ACKBIT);

`ifdef I2C_CLOCK_STRETCH_EN
    // A slave holding SCL low while we release it freezes the current quarter.
    assign hold = scl && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold          = 1'b0;
`endif

    i2c_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .en    (timer_en),
        .hold  (hold),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            quarter_q   <= '0;
            bit_q       <= '0;
            cmd_q       <= CMD_START;
            rd_data_q   <= '0;
            ack_error_q <= 1'b0;
            park_scl_q  <= 1'b1;
            park_sda_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            quarter_q   <= quarter_d;
            bit_q       <= bit_d;
            cmd_q       <= cmd_d;
            rd_data_q   <= rd_data_d;
            ack_error_q <= ack_error_d;
            park_scl_q  <= park_scl_d;
            park_sda_q  <= park_sda_d;
        end
    end

    always_ff @(posedge clk) begin
        wdata_q    <= wdata_d;
        rd_ack_q   <= rd_ack_d;
        shift_q    <= shift_d;
        ack_samp_q <= ack_samp_d;
    end

    always_comb begin
        state_d     = state_q;
        quarter_d   = quarter_q;
        bit_d       = bit_q;
        cmd_d       = cmd_q;
        rd_data_d   = rd_data_q;
        ack_error_d = ack_error_q;
        park_scl_d  = park_scl_q;
        park_sda_d  = park_sda_q;
        wdata_d     = wdata_q;
        rd_ack_d    = rd_ack_q;
        shift_d     = shift_q;
        ack_samp_d  = ack_samp_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d     = cmd_e'(cmd);
                    wdata_d   = wr_data;
                    rd_ack_d  = rd_ack;
                    quarter_d = '0;
                    bit_d     = 3'd7;
                    unique case (cmd_e'(cmd))
                        CMD_START: state_d = ST_START;
                        CMD_STOP:  state_d = ST_STOP;
                        default:   state_d = ST_DATA;
                    endcase
                end
            end
            ST_START, ST_STOP: begin
                if (tick) begin
                    quarter_d = quarter_q + 2'd1;
                    if (quarter_is_last(quarter_q)) begin
                        state_d    = ST_DONE;
                        // Remember the final quarter so the bus holds it while idle.
                        park_scl_d = (state_q == ST_STOP);
                        park_sda_d = (state_q == ST_START);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    quarter_d = quarter_q + 2'd1;
                    if (quarter_q == 2'd2 && cmd_q == CMD_READ) begin
                        shift_d = {shift_q[6:0], sda_in};
                    end
                    if (quarter_is_last(quarter_q)) begin
                        if (bit_q == 3'd0) begin
                            state_d = ST_ACKBIT;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end
                end
            end
            ST_ACKBIT: begin
                if (tick) begin
                    quarter_d = quarter_q + 2'd1;
                    if (quarter_q == 2'd2) begin
                        ack_samp_d = sda_in;
                    end
                    if (quarter_is_last(quarter_q)) begin
                        state_d    = ST_DONE;
                        park_scl_d = 1'b0;
                        park_sda_d = 1'b0;
                        // Results become visible together with the done pulse.
                        if (cmd_q == CMD_WRITE) begin
                            ack_error_d = ack_samp_q;
                        end else begin
                            rd_data_d = shift_q;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        done      = (state_q == ST_DONE);
        rd_data   = rd_data_q;
        ack_error = ack_error_q;
        scl       = park_scl_q;
        sda_oe    = park_sda_q;

        unique case (state_q)
            ST_START: begin
                unique case (quarter_q)
                    2'd0:    begin scl = 1'b0; sda_oe = 1'b0; end
                    2'd1:    begin scl = 1'b1; sda_oe = 1'b0; end
                    2'd2:    begin scl = 1'b1; sda_oe = 1'b1; end
                    default: begin scl = 1'b0; sda_oe = 1'b1; end
                endcase
            end
            ST_STOP: begin
                unique case (quarter_q)
                    2'd0:    begin scl = 1'b0; sda_oe = 1'b1; end
                    2'd1:    begin scl = 1'b1; sda_oe = 1'b1; end
                    default: begin scl = 1'b1; sda_oe = 1'b0; end
                endcase
            end
            ST_DATA: begin
                scl    = (quarter_q == 2'd1) || (quarter_q == 2'd2);
                sda_oe = (cmd_q == CMD_WRITE) ? !wdata_q[bit_q] : 1'b0;
            end
            ST_ACKBIT: begin
                scl    = (quarter_q == 2'd1) || (quarter_q == 2'd2);
                sda_oe = (cmd_q == CMD_WRITE) ? 1'b0 : rd_ack_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Self-checking bench for i2c_byte_master: a reactive slave on the bus and a
// byte-level reference model of what each command must put on SCL/SDA.
module tb_i2c_byte_master;

    localparam int CLK_DIV  = 4;
    localparam int LAT_SS   = 4 * CLK_DIV + 1;
    localparam int LAT_DATA = 36 * CLK_DIV + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] wr_data;
    logic       rd_ack;
    logic       done;
    logic [7:0] rd_data;
    logic       ack_error;
    logic       scl;
    logic       scl_in;
    logic       sda_oe;
    logic       sda_in;

    logic slave_sda   = 1'b1;
    logic stretch_low = 1'b0;

    assign sda_in = !sda_oe && slave_sda;
    assign scl_in = scl && !stretch_low;

    always #5 clk = ~clk;

    i2c_byte_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .wr_data   (wr_data),
        .rd_ack    (rd_ack),
        .done      (done),
        .rd_data   (rd_data),
        .ack_error (ack_error),
        .scl       (scl),
        .scl_in    (scl_in),
        .sda_oe    (sda_oe),
        .sda_in    (sda_in)
    );

    int checks   = 0;
    int failures = 0;

    logic       model_ack_error;
    logic [7:0] model_rd_data;

    int         r_lat;
    int         r_rises;
    int         r_sfall_hi;
    int         r_srise_hi;
    logic [8:0] r_line;
    logic       r_oe_seen;
    logic       r_after_ok;

    // Nine SDA levels seen at SCL rising edges: eight data bits then the ACK slot.
    function automatic logic [8:0] exp_line(input logic is_read, input logic [7:0] data,
                                            input logic rdack, input logic [7:0] sbyte,
                                            input logic sack);
        if (is_read) return {sbyte, !rdack};
        return {data, sack};
    endfunction

    task automatic run_cmd(input logic [1:0] c_cmd, input logic [7:0] c_data,
                           input logic c_rdack, input logic [8:0] pattern,
                           input int stretch_rise);
        int   c;
        int   n;
        int   stretch_left;
        logic prev_scl;
        logic prev_line;
        n = 0;
        while (!cmd_ready && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        cmd = c_cmd; wr_data = c_data; rd_ack = c_rdack; cmd_valid = 1'b1;
        prev_scl = scl; prev_line = sda_in;
        r_rises = 0; r_sfall_hi = 0; r_srise_hi = 0; r_line = '0; r_oe_seen = 1'b0;
        r_lat = -1; c = 0; stretch_left = 0;
        while (c < 2000 && r_lat < 0) begin
            @(posedge clk); #1; c++;
            if (c == 1) cmd_valid = 1'b0;
            if (stretch_left > 0) begin
                stretch_left--;
                if (stretch_left == 0) stretch_low = 1'b0;
            end
            if (scl && !prev_scl) begin
                if (r_rises < 9) r_line[8 - r_rises] = sda_in;
                if (r_rises == stretch_rise) begin
                    stretch_low  = 1'b1;
                    stretch_left = 20;
                end
                r_rises++;
            end
            if (scl && prev_scl && (sda_in !== prev_line)) begin
                if (!sda_in) r_sfall_hi++;
                else         r_srise_hi++;
            end
            if (sda_oe) r_oe_seen = 1'b1;
            if (!scl) slave_sda = (r_rises < 9) ? pattern[8 - r_rises] : 1'b1;
            prev_scl  = scl;
            prev_line = sda_in;
            if (done) r_lat = c;
        end
        slave_sda = 1'b1;
        @(posedge clk); #1;
        r_after_ok = (done === 1'b0) && (cmd_ready === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd = 2'd0; wr_data = 8'h00; rd_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_ack_error = 1'b0;
        model_rd_data   = 8'h00;
        @(posedge clk); #1;
        checks++; if (scl !== 1'b1)       begin failures++; $display("FAIL reset_scl got=%b exp=1", scl); end
        checks++; if (sda_oe !== 1'b0)    begin failures++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (rd_data !== 8'h00)  begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        checks++; if (ack_error !== 1'b0) begin failures++; $display("FAIL reset_ack_error got=%b exp=0", ack_error); end
    endtask

    task automatic test_start_stop();
        run_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, -1);
        checks++; if (r_lat != LAT_SS) begin failures++; $display("FAIL start_latency got=%0d exp=%0d", r_lat, LAT_SS); end
        checks++; if (r_sfall_hi != 1 || r_srise_hi != 0) begin failures++;
            $display("FAIL start_condition got=fall%0d/rise%0d exp=fall1/rise0", r_sfall_hi, r_srise_hi); end
        checks++; if (scl !== 1'b0 || sda_oe !== 1'b1) begin failures++;
            $display("FAIL start_park got=scl%b/oe%b exp=scl0/oe1", scl, sda_oe); end
        checks++; if (!r_after_ok) begin failures++; $display("FAIL start_done_width got=0 exp=1"); end
        run_cmd(2'd1, 8'h00, 1'b0, 9'h1FF, -1);
        checks++; if (r_lat != LAT_SS) begin failures++; $display("FAIL stop_latency got=%0d exp=%0d", r_lat, LAT_SS); end
        checks++; if (r_srise_hi != 1 || r_sfall_hi != 0) begin failures++;
            $display("FAIL stop_condition got=fall%0d/rise%0d exp=fall0/rise1", r_sfall_hi, r_srise_hi); end
        checks++; if (scl !== 1'b1 || sda_oe !== 1'b0) begin failures++;
            $display("FAIL stop_bus_idle got=scl%b/oe%b exp=scl1/oe0", scl, sda_oe); end
    endtask

    task automatic test_write_ack();
        logic [8:0] exp;
        run_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, -1);
        run_cmd(2'd2, 8'hB0, 1'b0, 9'h1FE, -1);
        model_ack_error = 1'b0;
        exp = exp_line(1'b0, 8'hB0, 1'b0, 8'h00, 1'b0);
        checks++; if (r_rises != 9) begin failures++; $display("FAIL write_scl_pulses got=%0d exp=9", r_rises); end
        checks++; if (r_line !== exp) begin failures++; $display("FAIL write_sda_bits got=%h exp=%h", r_line, exp); end
        checks++; if (r_lat != LAT_DATA) begin failures++; $display("FAIL write_latency got=%0d exp=%0d", r_lat, LAT_DATA); end
        checks++; if (ack_error !== model_ack_error) begin failures++;
            $display("FAIL write_ack_error got=%b exp=%b", ack_error, model_ack_error); end
        checks++; if (r_sfall_hi + r_srise_hi != 0) begin failures++;
            $display("FAIL write_sda_stable got=%0d exp=0", r_sfall_hi + r_srise_hi); end
    endtask

    task automatic test_write_nack();
        run_cmd(2'd2, 8'h30, 1'b0, 9'h1FF, -1);
        model_ack_error = 1'b1;
        checks++; if (ack_error !== model_ack_error) begin failures++;
            $display("FAIL nack_ack_error got=%b exp=%b", ack_error, model_ack_error); end
        run_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, -1);
        checks++; if (ack_error !== model_ack_error) begin failures++;
            $display("FAIL nack_held got=%b exp=%b", ack_error, model_ack_error); end
    endtask

    task automatic test_read();
        logic [8:0] exp;
        run_cmd(2'd3, 8'h00, 1'b0, {8'h5A, 1'b1}, -1);
        model_rd_data = 8'h5A;
        exp = exp_line(1'b1, 8'h00, 1'b0, 8'h5A, 1'b1);
        checks++; if (rd_data !== model_rd_data) begin failures++; $display("FAIL read_data got=%h exp=%h", rd_data, model_rd_data); end
        checks++; if (r_oe_seen !== 1'b0) begin failures++; $display("FAIL read_sda_released got=%b exp=0", r_oe_seen); end
        checks++; if (r_line !== exp) begin failures++; $display("FAIL read_line got=%h exp=%h", r_line, exp); end
        checks++; if (r_lat != LAT_DATA) begin failures++; $display("FAIL read_latency got=%0d exp=%0d", r_lat, LAT_DATA); end
    endtask

    task automatic test_reset_mid();
        logic [8:0] exp;
        cmd = 2'd2; wr_data = 8'hA5; rd_ack = 1'b0; cmd_valid = 1'b1;
        // Bit 3 is the fifth bit on the wire; land inside its SCL-high quarter.
        repeat (1 + 4 * CLK_DIV * 4 + CLK_DIV + 1) begin
            @(posedge clk); #1; cmd_valid = 1'b0;
        end
        reset = 1'b1;
        #1;
        checks++; if (scl !== 1'b1)       begin failures++; $display("FAIL midreset_scl got=%b exp=1", scl); end
        checks++; if (sda_oe !== 1'b0)    begin failures++; $display("FAIL midreset_sda_oe got=%b exp=0", sda_oe); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL midreset_cmd_ready got=%b exp=1", cmd_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_ack_error = 1'b0;
        model_rd_data   = 8'h00;
        @(posedge clk); #1;
        run_cmd(2'd2, 8'h3C, 1'b0, 9'h1FE, -1);
        exp = exp_line(1'b0, 8'h3C, 1'b0, 8'h00, 1'b0);
        checks++; if (r_line !== exp) begin failures++; $display("FAIL midreset_next_write got=%h exp=%h", r_line, exp); end
        checks++; if (r_lat != LAT_DATA) begin failures++; $display("FAIL midreset_latency got=%0d exp=%0d", r_lat, LAT_DATA); end
    endtask

    task automatic test_back_to_back();
        int c;
        int lat1;
        int lat2;
        lat1 = -1; lat2 = -1; c = 0;
        cmd = 2'd2; wr_data = 8'h96; rd_ack = 1'b0; cmd_valid = 1'b1;
        while (c < 2000 && lat1 < 0) begin
            @(posedge clk); #1; c++;
            if (c == 1) cmd = 2'd0;
            if (done) lat1 = c;
        end
        model_ack_error = 1'b1;
        checks++; if (lat1 != LAT_DATA) begin failures++; $display("FAIL b2b_busy_ignored got=%0d exp=%0d", lat1, LAT_DATA); end
        @(posedge clk); #1;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_return got=%b exp=1", cmd_ready); end
        c = 0;
        while (c < 2000 && lat2 < 0) begin
            @(posedge clk); #1; c++;
            if (c == 1) cmd_valid = 1'b0;
            if (done) lat2 = c;
        end
        checks++; if (lat2 != LAT_SS) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat2, LAT_SS); end
        checks++; if (ack_error !== model_ack_error) begin failures++;
            $display("FAIL b2b_ack_error got=%b exp=%b", ack_error, model_ack_error); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic       is_read;
        logic [7:0] data;
        logic       rdack;
        logic [7:0] sbyte;
        logic       sack;
        logic [8:0] exp;
        for (int i = 0; i < 8; i++) begin
            is_read = 1'($urandom_range(0, 1));
            data    = 8'($urandom);
            rdack   = 1'($urandom_range(0, 1));
            sbyte   = 8'($urandom);
            sack    = 1'($urandom_range(0, 1));
            if (is_read) begin
                run_cmd(2'd3, data, rdack, {sbyte, 1'b1}, -1);
                model_rd_data = sbyte;
            end else begin
                run_cmd(2'd2, data, rdack, {8'hFF, sack}, -1);
                model_ack_error = sack;
            end
            exp = exp_line(is_read, data, rdack, sbyte, sack);
            checks++; if (r_line !== exp) begin failures++; $display("FAIL rand%0d_line got=%h exp=%h", i, r_line, exp); end
            checks++; if (r_lat != LAT_DATA) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, r_lat, LAT_DATA); end
            checks++; if (rd_data !== model_rd_data || ack_error !== model_ack_error) begin failures++;
                $display("FAIL rand%0d_result got=%h/%b exp=%h/%b", i, rd_data, ack_error, model_rd_data, model_ack_error); end
            checks++; if (r_sfall_hi + r_srise_hi != 0) begin failures++;
                $display("FAIL rand%0d_sda_stable got=%0d exp=0", i, r_sfall_hi + r_srise_hi); end
            checks++; if (!r_after_ok) begin failures++; $display("FAIL rand%0d_done_width got=0 exp=1", i); end
        end
    endtask

`ifdef I2C_CLOCK_STRETCH_EN
    task automatic test_stretch();
        logic [8:0] exp;
        run_cmd(2'd2, 8'h5C, 1'b0, 9'h1FE, 2);
        model_ack_error = 1'b0;
        exp = exp_line(1'b0, 8'h5C, 1'b0, 8'h00, 1'b0);
        checks++; if (r_lat != LAT_DATA + 20) begin failures++; $display("FAIL stretch_latency got=%0d exp=%0d", r_lat, LAT_DATA + 20); end
        checks++; if (r_line !== exp) begin failures++; $display("FAIL stretch_data got=%h exp=%h", r_line, exp); end
    endtask
`endif

    initial begin
        test_reset();
        test_start_stop();
        test_write_ack();
        test_write_nack();
        test_read();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef I2C_CLOCK_STRETCH_EN
        test_stretch();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
